// File: rtl/alu_muldiv_unit_if.sv
// Pipeline-side bundle for alu_muldiv_unit: ID/EX decode and operands in, HI/LO and status out.
// The pipeline drives the master side and the unit is the slave.
interface alu_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [5:0]            ALUOp;
  logic [5:0]            funct;
  logic                  op_valid;
  logic                  flush;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;
  logic [DATA_WIDTH-1:0] mf_result;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic                  illegal_op;

  modport master (
    output ALUOp, funct, op_valid, flush, rs_data, rt_data,
    input  hi_out, lo_out, mf_result, stall, busy, done, div_by_zero, illegal_op
  );

  modport slave (
    input  ALUOp, funct, op_valid, flush, rs_data, rt_data,
    output hi_out, lo_out, mf_result, stall, busy, done, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply, restoring divide.
// Define ALU_MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU raise illegal_op.
module alu_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic             clk,
  input logic             reset,
  alu_muldiv_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
  typedef enum logic {OP_MUL, OP_DIV} op_e;

  state_e               state_q;
  op_e                  op_q;
  logic                 sgn_rs_q, sgn_rt_q;
  logic [W-1:0]         opb_q;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         hi_q, lo_q;
  logic                 busy_q, done_q, dbz_q, illegal_q;

  logic dec_en, is_mfhi, is_mthi, is_mflo, is_mtlo, is_mul, is_div, is_signed;
  logic can_issue, start_mul, start_div, illegal_d;
  logic rs_neg, rt_neg;
  logic [W-1:0] rs_mag, rt_mag;

  assign dec_en    = bus.op_valid && (bus.ALUOp == 6'b000000);
  assign is_mfhi   = dec_en && (bus.funct == F_MFHI);
  assign is_mthi   = dec_en && (bus.funct == F_MTHI);
  assign is_mflo   = dec_en && (bus.funct == F_MFLO);
  assign is_mtlo   = dec_en && (bus.funct == F_MTLO);
  assign is_mul    = dec_en && ((bus.funct == F_MULT) || (bus.funct == F_MULTU));
  assign is_div    = dec_en && ((bus.funct == F_DIV) || (bus.funct == F_DIVU));
  assign is_signed = ~bus.funct[0];
  assign can_issue = !busy_q && !bus.flush;
  assign start_mul = is_mul && can_issue;

`ifdef ALU_MULDIV_DIV_EN
  assign start_div = is_div && can_issue;
  assign illegal_d = 1'b0;
`else
  assign start_div = 1'b0;
  assign illegal_d = is_div && can_issue;
`endif

  // The iteration runs on magnitudes; signs are reapplied in FIX.
  assign rs_neg = is_signed && bus.rs_data[W-1];
  assign rt_neg = is_signed && bus.rt_data[W-1];
  assign rs_mag = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag = rt_neg ? -bus.rt_data : bus.rt_data;

  logic [W-1:0]   mul_addend;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fix_hi, fix_lo;
  logic           fix_dbz;
`ifdef ALU_MULDIV_DIV_EN
  logic [W:0]     div_part;
  logic [W+1:0]   div_diff;
  logic [W-1:0]   quo, rem;
`endif

  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
    acc_d      = {mul_sum, acc_q[W-1:1]};
    prod_fix   = (sgn_rs_q ^ sgn_rt_q) ? -acc_q : acc_q;
    fix_hi     = prod_fix[2*W-1:W];
    fix_lo     = prod_fix[W-1:0];
    fix_dbz    = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    div_part = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = {1'b0, div_part} - {2'b00, opb_q};
    quo      = acc_q[W-1:0];
    rem      = acc_q[2*W-1:W];
    if (op_q == OP_DIV) begin
      if (div_diff[W+1]) acc_d = {div_part[W-1:0], acc_q[W-2:0], 1'b0};
      else               acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      // A zero divisor never borrows, so the remainder ends as |rs| and re-signs back to rs.
      fix_dbz = (opb_q == '0);
      fix_hi  = sgn_rs_q ? -rem : rem;
      fix_lo  = fix_dbz ? '1 : ((sgn_rs_q ^ sgn_rt_q) ? -quo : quo);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      sgn_rs_q  <= 1'b0;
      sgn_rt_q  <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      illegal_q <= illegal_d;
      unique case (state_q)
        S_IDLE: begin
          if (start_mul || start_div) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            op_q     <= start_div ? OP_DIV : OP_MUL;
            sgn_rs_q <= rs_neg;
            sgn_rt_q <= rt_neg;
            opb_q    <= start_div ? rt_mag : rs_mag;
            acc_q    <= {{W{1'b0}}, (start_div ? rs_mag : rt_mag)};
          end else if (can_issue) begin
            if (is_mthi) hi_q <= bus.rs_data;
            if (is_mtlo) lo_q <= bus.rs_data;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(W - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            dbz_q  <= fix_dbz;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.mf_result   = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
  assign bus.stall       = (is_mfhi || is_mflo || is_mthi || is_mtlo || is_mul || is_div)
                           && busy_q && !bus.flush;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = illegal_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: results are predicted by a behavioural model into a
// scoreboard queue at issue time and compared when done pulses.
module tb_alu_muldiv_unit;
  localparam int DW = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.DATA_WIDTH(DW)) bus ();

  alu_muldiv_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [63:0] p;
    longint      q, r;
    e.hi = '0; e.lo = '0; e.dbz = 1'b0;
    case (f)
      F_MULT: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      F_MULTU: begin
        p = {32'b0, rs} * {32'b0, rt};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      F_DIV, F_DIVU: begin
        if (rt == 32'd0) begin
          e.hi = rs; e.lo = '1; e.dbz = 1'b1;
        end else if (f == F_DIV) begin
          q = longint'($signed(rs)) / longint'($signed(rt));
          r = longint'($signed(rs)) % longint'($signed(rt));
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          q = longint'({32'b0, rs}) / longint'({32'b0, rt});
          r = longint'({32'b0, rs}) % longint'({32'b0, rt});
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic idle_inputs();
    bus.ALUOp = 6'd0; bus.funct = 6'd0; bus.op_valid = 1'b0; bus.flush = 1'b0;
    bus.rs_data = '0; bus.rt_data = '0;
  endtask

  // Presents one instruction for a single edge; returns 1 time unit after that edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    bus.ALUOp = 6'd0; bus.funct = f; bus.op_valid = 1'b1;
    bus.rs_data = rs; bus.rt_data = rt;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.funct = 6'd0;
  endtask

  task automatic start_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    sb.push_back(model(f, rs, rt));
    issue(f, rs, rt);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    check({tag, " sb_pending"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " hi"}, 64'(bus.hi_out), 64'(e.hi));
      check({tag, " lo"}, 64'(bus.lo_out), 64'(e.lo));
      check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(e.dbz));
    end
  endtask

  // Returns at the falling edge of the cycle in which done is high.
  task automatic wait_done(input string tag, output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) compare_result(tag);
    else if (sb.size() > 0) sb.delete(0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, stalls, dones;
    logic [31:0] hi_save, lo_save, ra, rb;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hi_out", 64'(bus.hi_out), 64'd0);
    check("reset lo_out", 64'(bus.lo_out), 64'd0);
    check("reset mf_result", 64'(bus.mf_result), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    check("reset illegal_op", 64'(bus.illegal_op), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Signed multiply with timing.
    start_op(F_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult_neg", n);
    check("mult_neg busy_cycles", 64'(n), 64'd33);
    check("mult_neg hi_const", 64'(bus.hi_out), 64'hFFFF_FFFF);
    check("mult_neg lo_const", 64'(bus.lo_out), 64'hFFFF_FFFA);
    @(negedge clk);
    check("mult_neg done_one_cycle", 64'(bus.done), 64'd0);
    check("mult_neg busy_after", 64'(bus.busy), 64'd0);

    // MULTU then MULT accepted back-to-back in the done cycle.
    start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", n);
    start_op(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_m1", n2);
    check("back_to_back busy_cycles", 64'(n2), 64'd33);
    check("mult_m1 lo_const", 64'(bus.lo_out), 64'd1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      start_op((i % 2 == 0) ? F_MULT : F_MULTU, ra, rb);
      wait_done("mul_rand", n);
    end

`ifdef ALU_MULDIV_DIV_EN
    start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", n);
    check("div_m7_2 busy_cycles", 64'(n), 64'd33);
    start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_m1", n);
    check("div_min_m1 lo_const", 64'(bus.lo_out), 64'h8000_0000);
    start_op(F_DIVU, 32'd7, 32'd0);
    wait_done("divu_by_zero", n);
    check("divu_by_zero done", 64'(bus.done), 64'd1);
    check("divu_by_zero illegal_op", 64'(bus.illegal_op), 64'd0);
    @(negedge clk);
    check("divu_by_zero dbz_one_cycle", 64'(bus.div_by_zero), 64'd0);
    start_op(F_DIV, 32'hFFFF_FF00, 32'd0);
    wait_done("div_neg_by_zero", n);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom >> (i * 8);
      start_op((i % 2 == 0) ? F_DIV : F_DIVU, ra, rb);
      wait_done("div_rand", n);
    end
`else
    hi_save = bus.hi_out; lo_save = bus.lo_out;
    issue(F_DIVU, 32'd7, 32'd0);
    @(negedge clk);
    check("nodiv illegal_op", 64'(bus.illegal_op), 64'd1);
    check("nodiv busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("nodiv illegal_one_cycle", 64'(bus.illegal_op), 64'd0);
    check("nodiv hi_kept", 64'(bus.hi_out), 64'(hi_save));
    check("nodiv lo_kept", 64'(bus.lo_out), 64'(lo_save));
    start_op(F_MULT, 32'd9, 32'd9);
    bus.funct = F_DIV; bus.op_valid = 1'b1;
    @(negedge clk);
    check("nodiv div_stalls_on_mul", 64'(bus.stall), 64'd1);
    bus.op_valid = 1'b0; bus.funct = 6'd0;
    wait_done("nodiv mult", n);
`endif

    // MFLO right behind a MULTU stalls, then forwards the new LO.
    start_op(F_MULTU, 32'd5, 32'd6);
    bus.funct = F_MFLO; bus.op_valid = 1'b1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
    end
    check("mflo stall_cycles", 64'(stalls), 64'd33);
    check("mflo mf_result", 64'(bus.mf_result), 64'd30);
    check("mflo done", 64'(bus.done), 64'd1);
    compare_result("multu_5_6");
    @(posedge clk); #1;
    bus.funct = F_MFHI;
    @(negedge clk);
    check("mfhi mf_result", 64'(bus.mf_result), 64'd0);
    bus.op_valid = 1'b0; bus.funct = 6'd0;

    // MTLO while busy is held off, then applied.
    start_op(F_MULT, 32'd3, 32'd7);
    bus.funct = F_MTLO; bus.op_valid = 1'b1; bus.rs_data = 32'h1234;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
    end
    check("mtlo stall_cycles", 64'(stalls), 64'd33);
    compare_result("mult_3_7");
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.funct = 6'd0;
    @(negedge clk);
    check("mtlo applied", 64'(bus.lo_out), 64'h1234);

    // Flush at iteration 10 leaves preset HI/LO alone.
    issue(F_MTHI, 32'hAAAA, 32'd0);
    issue(F_MTLO, 32'h5555, 32'd0);
`ifdef ALU_MULDIV_DIV_EN
    issue(F_DIV, 32'd1000, 32'd7);
`else
    issue(F_MULT, 32'd1000, 32'd7);
`endif
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush done", 64'(bus.done), 64'd0);
    check("flush hi_kept", 64'(bus.hi_out), 64'hAAAA);
    check("flush lo_kept", 64'(bus.lo_out), 64'h5555);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush no_done", 64'(dones), 64'd0);

    // Start coinciding with flush, and a non-R-type opcode, are both ignored.
    bus.flush = 1'b1;
    issue(F_MULT, 32'd2, 32'd2);
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start busy", 64'(bus.busy), 64'd0);
    bus.ALUOp = 6'b000001; bus.funct = F_MULT; bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.ALUOp = 6'd0; bus.funct = 6'd0;
    @(negedge clk);
    check("aluop_nonzero busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-multiply clears everything at once.
    issue(F_MULT, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    #3;
    bus.funct = F_MFHI; bus.op_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_mid hi_out", 64'(bus.hi_out), 64'd0);
    check("rst_mid lo_out", 64'(bus.lo_out), 64'd0);
    check("rst_mid busy", 64'(bus.busy), 64'd0);
    check("rst_mid stall", 64'(bus.stall), 64'd0);
    check("rst_mid mf_result", 64'(bus.mf_result), 64'd0);
    check("rst_mid done", 64'(bus.done), 64'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid stays_idle", 64'(bus.busy), 64'd0);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Iterative multiply/divide unit for the execution stage, beside the ALU. It decodes the R-type HI/LO instructions from `ALUOp`/`funct`, runs signed and unsigned multiply and divide over `DATA_WIDTH` cycles, and owns the architectural HI/LO registers. It tells the pipeline when to stall and serves MFHI/MFLO reads.

## Interface
- `DATA_WIDTH`, default 32: operand width, and width of HI and LO each.
- `CNT_WIDTH`, default 6: iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports, clock and reset first:
- `clk` input 1: single clock, all state on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `ALUOp` input 6: opcode from ID/EX; the unit acts only when it is 6'b000000.
- `funct` input 6: function field.
- `op_valid` input 1: the ID/EX instruction is valid (not a bubble).
- `flush` input 1: squashes the ID/EX instruction and aborts any in-flight operation.
- `rs_data` input DATA_WIDTH: dividend or multiplicand; source for MTHI/MTLO.
- `rt_data` input DATA_WIDTH: divisor or multiplier.
- `hi_out` output DATA_WIDTH: HI register.
- `lo_out` output DATA_WIDTH: LO register.
- `mf_result` output DATA_WIDTH: HI for MFHI, LO for MFLO, 0 otherwise (combinational).
- `stall` output 1: hold IF/ID/EX this cycle (combinational).
- `busy` output 1: an operation is in flight (registered).
- `done` output 1: one-cycle pulse after HI/LO are written by MULT*/DIV*.
- `div_by_zero` output 1: one-cycle pulse, coincident with `done`, when the divisor was 0.
- `illegal_op` output 1: one-cycle pulse when a compiled-out op is presented.

## Operation
- Decode, valid only with `ALUOp`==0 and `op_valid`: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Every other `funct` is ignored.
- **Acceptance:** a MULT*/DIV* is accepted on the edge where it is decoded, `busy`=0 and `flush`=0.
  - The unit latches operand magnitudes, the sign of each, and the op type.
  - The counter loads 0 and the state moves IDLE->RUN.
- **RUN:**
  - Multiply: radix-2 shift-add on a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - One iteration per cycle; after DATA_WIDTH iterations the state moves to FIX.
- **FIX, one cycle:**
  - Signed ops apply sign correction. Product sign = sign_rs XOR sign_rt; quotient likewise; remainder takes the sign of rs.
  - HI/LO are written and the state returns to IDLE.
- **Results:**
  - Product: HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder.
  - Signed divide of min-negative by -1 gives LO = min-negative, HI = 0.
- **Divide by zero:** HI = `rs_data` as latched, LO = all ones, `div_by_zero` pulses.
- **MTHI/MTLO:** write `rs_data` to HI/LO on the edge, only when `busy`=0 and `flush`=0.
- **`stall`** = decoded MFHI, MFLO, MTHI, MTLO, MULT* or DIV* AND `busy`=1 AND `flush`=0.
- **Flush:** `flush` returns RUN or FIX to IDLE with HI/LO unchanged and no `done`. When `flush` coincides with a start, the start is ignored.
- **Reset:** `reset` at any time forces IDLE; HI, LO, counter and all outputs become 0.

## Timing
- Accept edge E0.
- Iteration edges E1..E(DATA_WIDTH).
- FIX edge E(DATA_WIDTH+1) writes HI/LO.
- `busy` is high from after E0 until after E(DATA_WIDTH+1), i.e. DATA_WIDTH+1 cycles.
- `done` and `div_by_zero` are high for the single cycle after E(DATA_WIDTH+1).
- An MFHI/MFLO presented in the cycle after E0 stalls DATA_WIDTH+1 cycles, then reads the new value (`mf_result` is combinational from the registers).
- Back-to-back: a new MULT*/DIV* can be accepted in the cycle `done` is high.
- Reset values: `hi_out`=0, `lo_out`=0, `mf_result`=0, `stall`=0, `busy`=0, `done`=0, `div_by_zero`=0, `illegal_op`=0.

## Configuration
- `ALU_MULDIV_DIV_EN` defined: DIV/DIVU are implemented as above.
- Undefined:
  - The divider datapath is omitted.
  - A decoded DIV/DIVU is not accepted: `busy` stays low and HI/LO are unchanged.
  - `illegal_op` pulses for one cycle on the following edge.
  - `stall` still asserts for DIV/DIVU while a multiply is in flight.

## Test plan
- **Signed multiply:** MULT rs=0xFFFFFFFE, rt=3 at E0 -> `busy` for 33 cycles; `done` in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Unsigned multiply:** MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat with MULT on the same operands -> HI=0, LO=1.
- **Signed divide:** DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- **Divide by zero:** DIVU 7/0 -> HI=7, LO=0xFFFFFFFF, `div_by_zero` and `done` pulse together. Without `ALU_MULDIV_DIV_EN`: `illegal_op` pulses, `busy` stays 0.
- **Stall and forwarding:** MULTU 5*6 followed immediately by MFLO -> `stall` high 33 cycles, then `mf_result`=30. MTLO 0x1234 while `busy` -> stalled, then applied after `done`.
- **Flush and reset:** `flush` at iteration 10 of DIV with HI/LO preset by MTHI 0xAAAA / MTLO 0x5555 -> `busy`=0 next cycle, no `done`, HI/LO unchanged. `reset` mid-MULT -> all outputs 0 immediately.
